seq_scan_ctrl: RTL
==================

# seq_scan_ctrl

Sequencing controller for the serial sequence-detection datapath. It accepts parallel words from a requester over a valid/ready handshake and serializes each word MSB-first into an embedded pattern-match core. It counts pattern matches per word and reports the count with a one-cycle completion strobe. The match pattern is software-programmable between words.

## Interface
- `WORD_W`, 16: bits per input word; must be ≥ `PAT_W`.
- `PAT_W`, 4: pattern length in bits.
- `CNT_W`, 8: match counter width.
- `DEF_PATTERN`, `4'b1010`: pattern value after reset.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `cfg_we` in 1: pattern write strobe; honoured only in IDLE.
- `cfg_pattern` in `PAT_W`: new pattern, written when `cfg_we` is honoured.
- `in_valid` in 1: requester has a word.
- `in_ready` out 1: controller can accept a word. High only in IDLE.
- `in_data` in `WORD_W`: word to scan.
- `ser_bit` out 1: bit currently presented to the match core (debug).
- `busy` out 1: high in SHIFT and REPORT.
- `match_pulse` out 1: registered, one cycle per detected match.
- `done` out 1: one-cycle strobe in REPORT.
- `match_count` out `CNT_W`: matches in the current/last word. Held until the next accept.

## Operation
- FSM states:
  - IDLE → SHIFT on `in_valid && in_ready`.
  - SHIFT → REPORT after `WORD_W` bits have been consumed.
  - REPORT → IDLE unconditionally.
- On accept:
  - capture `in_data` into the shift register;
  - clear the bit counter, `match_count`, and the match-core history and fill count.
  - No history carries across words.
- In SHIFT, each cycle:
  - `ser_bit` = shift-register MSB;
  - the core shifts it into a `PAT_W`-bit history;
  - the shift register shifts left;
  - the bit counter increments;
  - fill saturates at `PAT_W`.
- Match condition: next history == pattern and next fill ≥ `PAT_W`. A match registers `match_pulse` and increments `match_count` on the same edge.
- `match_count` saturates at 2^`CNT_W`−1 and never wraps.
- `cfg_we` outside IDLE is ignored. A pattern write in the same cycle as an accept takes effect for that word.
- `in_valid` while not in IDLE is not accepted. The requester must hold the word; `in_ready` gates the accept.
- `reset_n` low at any time, including mid-word:
  - state becomes IDLE; the word is abandoned;
  - pattern returns to `DEF_PATTERN`;
  - counters, history and fill are cleared.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `done`=0, `match_pulse`=0, `match_count`=0, `ser_bit`=0.
- Accept edge at end of cycle c:
  - SHIFT occupies cycles c+1 … c+`WORD_W`;
  - REPORT in cycle c+`WORD_W`+1, with `done`=1 and final `match_count` valid;
  - `in_ready` high again in cycle c+`WORD_W`+2.
- Throughput: one word per `WORD_W`+2 cycles.
- `match_pulse` latency: high in the cycle after the completing bit is on `ser_bit`. The pulse for the last bit coincides with `done`.
- `match_count` is registered and already includes the last bit's match when `done` is high.

## Configuration
- `SEQ_OVERLAP_EN` defined: overlapping detection. History and fill are kept after a match, so `1010` in `101010` matches twice.
- `SEQ_OVERLAP_EN` not defined: non-overlapping detection. Fill resets to 0 on a match, so the next match needs `PAT_W` fresh bits.
- The macro affects only the match core; FSM and timing are identical in both modes.

## Structure
- Package `seq_ctrl_pkg`:
  - `ctrl_state_t` enum, 2 bits: IDLE=0, SHIFT=1, REPORT=2. Encoding 3 is illegal and recovers to IDLE.
  - default width constants.
- Sub-module `seq_match_core`:
  - holds history, fill counter, pattern register and compare;
  - `SEQ_OVERLAP_EN` handling;
  - ports: `clk`, `reset_n`, `clr`, `shift_en`, `bit_in`, `cfg_we`, `cfg_pattern`, `match`.
- The controller holds the FSM, shift register, bit counter and saturating `match_count`.

## Test plan
- Reset: drive `reset_n`=0 → all outputs at reset values. After release, `in_ready`=1 and the pattern is `4'b1010`.
- Default pattern, word `16'hAAAA`:
  - overlap build: `match_count`=7 at `done`, with pulses after bits 4, 6, …, 16;
  - non-overlap build: `match_count`=4, with pulses after bits 4, 8, 12, 16.
- Word `16'h0000` accepted at cycle c → `done` exactly at c+17, `match_count`=0, `in_ready` back at c+18.
- `cfg_pattern`=`4'b1111` in IDLE, then word `16'hFFFF` → count 13 (overlap) or 4 (non-overlap).
- Accepted word `16'hA000` then `16'h000A`:
  - `cfg_we` during SHIFT is ignored;
  - `in_valid` during SHIFT is not accepted until IDLE;
  - the second word counts 1, with no cross-word match.
- `reset_n` pulsed low at SHIFT bit 9 → `busy`, `done` and `match_count` immediately 0. A fresh `16'hAAAA` then scans with `4'b1010`.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared state type and default widths for the serial sequence-scan controller.
// The match-core detection mode is selected by SEQ_OVERLAP_EN.
package seq_ctrl_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_PAT_W  = 4;
   localparam int DEF_CNT_W  = 8;
   localparam logic [DEF_PAT_W-1:0] DEF_PAT = 4'b1010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history + fill + programmable pattern; match is combinational on the incoming bit.
// SEQ_OVERLAP_EN defined keeps history/fill after a match; otherwise fill restarts so matches never overlap.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int               PAT_W       = DEF_PAT_W,
   parameter logic [PAT_W-1:0] DEF_PATTERN = DEF_PAT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   output logic             match
);

   localparam int                FILL_W   = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_nxt;
   logic [PAT_W-1:0]  pattern;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nxt;

   always_comb begin
      hist_nxt = {hist[PAT_W-2:0], bit_in};
      fill_nxt = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
      match    = shift_en && (hist_nxt == pattern) && (fill_nxt >= FILL_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         fill    <= '0;
         pattern <= DEF_PATTERN;
      end else begin
         if (cfg_we) begin
            pattern <= cfg_pattern;
         end
         if (clr) begin
            hist <= '0;
            fill <= '0;
         end else if (shift_en) begin
            hist <= hist_nxt;
`ifdef SEQ_OVERLAP_EN
            fill <= fill_nxt;
`else
            fill <= match ? '0 : fill_nxt;
`endif
         end
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word in IDLE, shifts it MSB-first into seq_match_core, reports the match count in REPORT (WORD_W+2 cycles/word).
// in_ready is high only in IDLE; the requester holds in_valid/in_data until accepted. Detection mode: SEQ_OVERLAP_EN.
module seq_scan_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int               WORD_W      = DEF_WORD_W,
   parameter int               PAT_W       = DEF_PAT_W,
   parameter int               CNT_W       = DEF_CNT_W,
   parameter logic [PAT_W-1:0] DEF_PATTERN = DEF_PAT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              ser_bit,
   output logic              busy,
   output logic              match_pulse,
   output logic              done,
   output logic [CNT_W-1:0]  match_count
);

   localparam int               BC_W     = $clog2(WORD_W);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   ctrl_state_t       state;
   ctrl_state_t       state_nxt;
   logic [WORD_W-1:0] sreg;
   logic [BC_W-1:0]   bit_cnt;
   logic              accept;
   logic              shift_en;
   logic              cfg_ok;
   logic              core_match;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept  = in_valid && in_ready;
   assign cfg_ok  = cfg_we && in_ready;
   assign ser_bit = shift_en && sreg[WORD_W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sreg        <= '0;
         bit_cnt     <= '0;
         match_count <= '0;
         match_pulse <= 1'b0;
      end else begin
         match_pulse <= core_match;
         if (accept) begin
            sreg        <= in_data;
            bit_cnt     <= '0;
            match_count <= '0;
         end else if (shift_en) begin
            sreg    <= {sreg[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BC_W'(1);
            // saturate rather than wrap so a long word never reports a small count
            if (core_match && (match_count != CNT_MAX)) begin
               match_count <= match_count + CNT_W'(1);
            end
         end
      end
   end

   seq_match_core #(
      .PAT_W       (PAT_W),
      .DEF_PATTERN (DEF_PATTERN)
   ) u_core (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (accept),
      .shift_en    (shift_en),
      .bit_in      (ser_bit),
      .cfg_we      (cfg_ok),
      .cfg_pattern (cfg_pattern),
      .match       (core_match)
   );

endmodule
